multiword_add_seq: RTL and testbench

- Sequencer that reuses a single WIDTH-bit full-adder datapath to add two NWORDS-word operands, one word per cycle, least-significant word first.
- The carry ripples between words through an internal carry register.
- Sits between a requester using a start/busy/done handshake and wide arithmetic consumers that cannot afford a full-width adder.
- Result is presented as registered sum and cout, held stable until the next accepted start.

---
 rtl/multiword_add_seq.sv | 195 +++++++++++++++++++
 tb/tb_multiword_add_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
//
// Adds two wide operands (WIDTH*NWORDS bits) using a single WIDTH-bit adder.
// It processes one word per clock, least-significant word first. The carry
// between words is held in a carry register. The finished result is
// registered and held until the next accepted start.
//
// Parameters:
//   WIDTH   word width of the shared adder datapath (>= 1)
//   NWORDS  number of words per operand (>= 1)
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    asynchronous active-high reset
//   start_i  request, sampled only in IDLE or DONE
//   a_i      operand A, captured on accepted start
//   b_i      operand B, captured on accepted start
//   cin_i    carry into word 0, captured on accepted start
//   sub_i    (MWADD_SUB_EN only) subtract request, captured on accepted start
//   busy_o   high while the word loop is running
//   done_o   one-cycle pulse when a result has just been written
//   sum_o    result of the last completed operation
//   cout_o   carry out of the top word of the last completed operation
//
// Optional feature macro: MWADD_SUB_EN
//   When defined, adds sub_i. With sub_i=1 the operation is a - b:
//   B is inverted at capture and the initial carry is forced to 1.
//   In that mode cout_o=1 means no borrow.
// -----------------------------------------------------------------------------
module multiword_add_seq #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WIDTH*NWORDS-1:0]  a_i,
  input  logic [WIDTH*NWORDS-1:0]  b_i,
  input  logic                     cin_i,
`ifdef MWADD_SUB_EN
  input  logic                     sub_i,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH*NWORDS-1:0]  sum_o,
  output logic                     cout_o
);

  localparam int N    = WIDTH * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      opA_q, opA_d;
  logic [N-1:0]      opB_q, opB_d;
  logic [N-1:0]      work_q, work_d;
  logic [N-1:0]      sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;

  logic              subMode;
  logic [N-1:0]      bEff;
  logic              carryInit;
  logic              accept;
  logic [WIDTH-1:0]  wordA;
  logic [WIDTH-1:0]  wordB;
  logic [WIDTH:0]    wordSum;

  // The operand transform for subtraction is applied once, at capture.
  // This keeps the per-word loop identical for add and subtract: a - b is
  // a + ~b + 1, and the "+1" enters through the initial carry.
`ifdef MWADD_SUB_EN
  assign subMode = sub_i;
`else
  assign subMode = 1'b0;
`endif
  assign bEff      = subMode ? ~b_i : b_i;
  assign carryInit = subMode ? 1'b1 : cin_i;

  // A new request is taken in IDLE, or in DONE for back-to-back operation.
  // A start that arrives while running is deliberately dropped.
  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

  // Select the current word of each captured operand. This uses an explicit
  // comparison per word, which keeps the index width-clean and out of range
  // of nothing.
  always_comb begin
    wordA = '0;
    wordB = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        wordA = opA_q[w*WIDTH +: WIDTH];
        wordB = opB_q[w*WIDTH +: WIDTH];
      end
    end
  end

  // The shared adder is WIDTH+1 bits wide, so the top bit is the word carry.
  assign wordSum = {1'b0, wordA} + {1'b0, wordB} + {{WIDTH{1'b0}}, carry_q};

  // Next-state and datapath update. The work register collects partial
  // words. The visible sum/cout registers only change on the final word,
  // so a consumer never sees a half-built result.
  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          opA_d   = a_i;
          opB_d   = bEff;
          carry_d = carryInit;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int w = 0; w < NWORDS; w++) begin
          if (idx_q == IDXW'(w)) begin
            work_d[w*WIDTH +: WIDTH] = wordSum[WIDTH-1:0];
          end
        end
        carry_d = wordSum[WIDTH];
        if (idx_q == LAST_IDX) begin
          sum_d   = work_d;
          cout_d  = wordSum[WIDTH];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. The asynchronous reset drops any operation in flight,
  // together with its partial result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. Their reset behaviour matches the state register,
  // so outputs read zero as soon as reset asserts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opA_q   <= '0;
      opB_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// -----------------------------------------------------------------------------
// tb_multiword_add_seq
//
// Testbench for multiword_add_seq with WIDTH=4 and NWORDS=4 (16-bit operands).
// Expected results come from whole-operand integer arithmetic. Expected
// timing comes from the documented latency: done follows the accept edge
// by NWORDS edges.
// Define MWADD_SUB_EN to also exercise the subtract mode.
// -----------------------------------------------------------------------------
module tb_multiword_add_seq;

  localparam int WIDTH  = 4;
  localparam int NWORDS = 4;
  localparam int N      = WIDTH * NWORDS;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [N-1:0]  a_i;
  logic [N-1:0]  b_i;
  logic          cin_i;
`ifdef MWADD_SUB_EN
  logic          sub_i;
`endif
  logic          busy_o;
  logic          done_o;
  logic [N-1:0]  sum_o;
  logic          cout_o;

  int vectors     = 0;
  int miscompares = 0;

  multiword_add_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
`ifdef MWADD_SUB_EN
    .sub_i   (sub_i),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
  );

  // The clock period is 10. Inputs change and outputs are sampled 1 unit
  // after each rising edge.
  always #5 clk_i = ~clk_i;

  // Reference model computed on whole operands, returned as {cout, sum}.
  function automatic logic [N:0] refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic cin, input logic sub);
    int unsigned av;
    int unsigned bv;
    av = a;
    bv = b;
    if (sub) return {(av >= bv), N'(av - bv)};
    else     return (N+1)'(av + bv + cin);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present operands, hold start across one rising edge (edge k), then drop
  // start. The task returns 1 unit after edge k.
  task automatic startOp(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic sub);
    a_i     = a;
    b_i     = b;
    cin_i   = cin;
`ifdef MWADD_SUB_EN
    sub_i   = sub;
`else
    if (sub) $display("[TB] subtract requested without MWADD_SUB_EN");
`endif
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Step until done is seen. The wait is bounded. The number of edges taken
  // is returned, and a timeout shows up as a wrong count.
  task automatic waitDone(output int edges);
    edges = 0;
    while (done_o !== 1'b1 && edges < 20) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
`ifdef MWADD_SUB_EN
    sub_i   = 1'b0;
`endif
    #2;
    vectors++;
    if ({busy_o, done_o, cout_o, sum_o} !== '0)
      $display("[TB] FAIL reset_state: got busy=%b done=%b cout=%b sum=%h, want all zero",
               busy_o, done_o, cout_o, sum_o);
    step();
    step();
    rst_i = 1'b0;
    step();
    vectors++;
    if ({busy_o, done_o} !== 2'b00)
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy_o, done_o);
    if ({busy_o, done_o} !== 2'b00) miscompares++;
    if ({busy_o, done_o, cout_o, sum_o} !== '0) miscompares++;
  endtask

  // Directed cases with full cycle-by-cycle handshake checks.
  task automatic test_directed();
    logic [N-1:0] ta [2];
    logic [N-1:0] tb [2];
    logic         tc [2];
    logic [N:0]   exp;
    ta[0] = 16'h1234; tb[0] = 16'h0001; tc[0] = 1'b0;
    ta[1] = 16'hFFFF; tb[1] = 16'h0000; tc[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      exp = refModel(ta[t], tb[t], tc[t], 1'b0);
      startOp(ta[t], tb[t], tc[t], 1'b0);
      for (int i = 0; i < NWORDS; i++) begin
        vectors++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL run_handshake case %0d cycle %0d: got busy=%b done=%b, want 1 0",
                   t, i, busy_o, done_o);
        end
        step();
      end
      vectors++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || {cout_o, sum_o} !== exp) begin
        miscompares++;
        $display("[TB] FAIL done_result case %0d: got done=%b busy=%b cout=%b sum=%h, want 1 0 %b %h",
                 t, done_o, busy_o, cout_o, sum_o, exp[N], exp[N-1:0]);
      end
      step();
      step();
      vectors++;
      if (done_o !== 1'b0 || {cout_o, sum_o} !== exp) begin
        miscompares++;
        $display("[TB] FAIL result_hold case %0d: got done=%b cout=%b sum=%h, want 0 %b %h",
                 t, done_o, cout_o, sum_o, exp[N], exp[N-1:0]);
      end
    end
  endtask

  // A start arriving mid-run must be ignored, and exactly one done must
  // follow the first request.
  task automatic test_ignore_start();
    int           pulses;
    logic [N-1:0] seenSum;
    logic         seenCout;
    pulses   = 0;
    seenSum  = 'x;
    seenCout = 1'bx;
    startOp(16'h8000, 16'h8000, 1'b0, 1'b0);
    step();
    a_i     = 16'h0001;
    b_i     = 16'h0001;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done_o === 1'b1) begin
        pulses++;
        seenSum  = sum_o;
        seenCout = cout_o;
      end
      step();
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_pulses: got %0d done pulses, want 1", pulses);
    end
    vectors++;
    if ({seenCout, seenSum} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_result: got cout=%b sum=%h, want 1 0000", seenCout, seenSum);
    end
  endtask

  // An asynchronous reset in the middle of a run clears everything before
  // the next edge. A later operation must then complete normally.
  task automatic test_async_reset();
    int edges;
    startOp(16'h00FF, 16'h0001, 1'b0, 1'b0);
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    vectors++;
    if ({busy_o, done_o, cout_o, sum_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b cout=%b sum=%h, want all zero",
               busy_o, done_o, cout_o, sum_o);
    end
    step();
    rst_i = 1'b0;
    step();
    startOp(16'h0002, 16'h0003, 1'b0, 1'b0);
    waitDone(edges);
    vectors++;
    if (edges !== NWORDS || {cout_o, sum_o} !== {1'b0, 16'h0005}) begin
      miscompares++;
      $display("[TB] FAIL after_reset_op: got edges=%0d cout=%b sum=%h, want %0d 0 0005",
               edges, cout_o, sum_o, NWORDS);
    end
    step();
  endtask

  // Start is held through the DONE cycle, so the next operation begins
  // without going back to IDLE.
  task automatic test_back_to_back();
    int edges;
    startOp(16'h0101, 16'h0202, 1'b0, 1'b0);
    waitDone(edges);
    vectors++;
    if (edges !== NWORDS || {cout_o, sum_o} !== {1'b0, 16'h0303}) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got edges=%0d cout=%b sum=%h, want %0d 0 0303",
               edges, cout_o, sum_o, NWORDS);
    end
    a_i     = 16'h0F0F;
    b_i     = 16'h00F1;
    cin_i   = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart: got busy=%b done=%b, want 1 0", busy_o, done_o);
    end
    waitDone(edges);
    vectors++;
    if (edges !== NWORDS || {cout_o, sum_o} !== {1'b0, 16'h1000}) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got edges=%0d cout=%b sum=%h, want %0d 0 1000",
               edges, cout_o, sum_o, NWORDS);
    end
    step();
  endtask

  // Random operations. The inputs are scrambled during each run to show that
  // only the captured copies matter.
  task automatic test_random();
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    logic [N:0]   exp;
    int           edges;
    for (int t = 0; t < 30; t++) begin
      ra  = N'($urandom);
      rb  = N'($urandom);
      rc  = 1'($urandom);
      exp = refModel(ra, rb, rc, 1'b0);
      startOp(ra, rb, rc, 1'b0);
      edges = 0;
      while (done_o !== 1'b1 && edges < 20) begin
        a_i   = N'($urandom);
        b_i   = N'($urandom);
        cin_i = 1'($urandom);
        step();
        edges++;
      end
      vectors++;
      if (edges !== NWORDS || {cout_o, sum_o} !== exp) begin
        miscompares++;
        $display("[TB] FAIL random_add %0d (a=%h b=%h cin=%b): got edges=%0d cout=%b sum=%h, want %0d %b %h",
                 t, ra, rb, rc, edges, cout_o, sum_o, NWORDS, exp[N], exp[N-1:0]);
      end
      if ($urandom_range(1, 0) == 1) step();
    end
  endtask

`ifdef MWADD_SUB_EN
  // Subtract mode. cin is driven randomly to show that it is ignored.
  task automatic test_subtract();
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N:0]   exp;
    int           edges;
    for (int t = 0; t < 12; t++) begin
      if (t == 0) begin
        ra = 16'h0005; rb = 16'h0007;
      end else if (t == 1) begin
        ra = 16'h0007; rb = 16'h0005;
      end else begin
        ra = N'($urandom);
        rb = N'($urandom);
      end
      exp = refModel(ra, rb, 1'b0, 1'b1);
      startOp(ra, rb, 1'($urandom), 1'b1);
      waitDone(edges);
      vectors++;
      if (edges !== NWORDS || {cout_o, sum_o} !== exp) begin
        miscompares++;
        $display("[TB] FAIL subtract %0d (a=%h b=%h): got edges=%0d cout=%b sum=%h, want %0d %b %h",
                 t, ra, rb, edges, cout_o, sum_o, NWORDS, exp[N], exp[N-1:0]);
      end
      step();
    end
    sub_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef MWADD_SUB_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
